// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection controller.
// Each lamp triplet is ordered {red, yellow, green}.
package traffic_pkg;

  typedef enum logic [1:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_FLASH
  } state_t;

  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] DARK   = 3'b000;

endpackage

// File: rtl/phase_timer.sv
// Down-counter shared by all timed phases. A load of D-1 makes expired rise
// on the D-th cycle of the phase.
module phase_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= RST_VAL;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expired = (cnt_reg == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// N-way round-robin traffic-light controller with demand-driven green,
// yellow and all-red clearance, plus a flashing night mode.
module intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int N_DIR     = 2,
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int FLASH_T   = 2,
  parameter int CNT_W     = 8,
  parameter int DW        = $clog2(N_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DIR-1:0]   sensor,
  input  logic               flash_req,
  output logic [3*N_DIR-1:0] lights,
  output logic [DW-1:0]      active_dir,
  output logic               handover
);

  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] FLASH_LD  = CNT_W'(FLASH_T - 1);
  localparam logic [CNT_W-1:0] GMIN_M1   = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_M1   = CNT_W'(GREEN_MAX - 1);
  localparam int MAX_T1 = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int MAX_T2 = (ALLRED_T > FLASH_T) ? ALLRED_T : FLASH_T;
  localparam int MAX_T  = (MAX_T1 > MAX_T2) ? MAX_T1 : MAX_T2;

  if (N_DIR < 2) begin : g_bad_ndir
    $error("intersection_ctrl: N_DIR must be at least 2");
  end
  if (GREEN_MIN < 1 || GREEN_MAX < GREEN_MIN) begin : g_bad_green
    $error("intersection_ctrl: need 1 <= GREEN_MIN <= GREEN_MAX");
  end
  if (YELLOW_T < 1 || ALLRED_T < 1 || FLASH_T < 1) begin : g_bad_times
    $error("intersection_ctrl: YELLOW_T, ALLRED_T and FLASH_T must be >= 1");
  end
  if (longint'(MAX_T - 1) >= (longint'(1) << CNT_W)) begin : g_bad_cnt_w
    $error("intersection_ctrl: CNT_W too narrow for the longest phase");
  end

  state_t             state_reg, state_next;
  logic [DW-1:0]      cur_reg, cur_next;
  logic [N_DIR-1:0]   pend_reg, pend_next;
  logic [CNT_W-1:0]   elapsed_reg, elapsed_next;
  logic               first_reg, first_next;
  logic               phase_reg, phase_next;

  logic               load;
  logic [CNT_W-1:0]   load_val;
  logic               expired;
  logic [N_DIR-1:0]   cur_mask;
  logic               demand;
  logic               go_yellow;
  logic [DW-1:0]      sel;
  logic [DW-1:0]      sel_idx;

  phase_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(ALLRED_LD)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .load_val(load_val),
    .expired (expired)
  );

  assign cur_mask  = N_DIR'(1) << cur_reg;
  assign demand    = |(pend_reg | (sensor & ~cur_mask));
  assign go_yellow = (elapsed_reg >= GMIN_M1) &&
                     (flash_req || (demand && (!sensor[cur_reg] || elapsed_reg >= GMAX_M1)));

  // Round-robin pick: nearest pending approach after cur wins; cur itself is
  // the last resort, and approach 0 is taken when nothing is pending.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    if (pend_reg[cur_reg]) sel = cur_reg;
    for (int k = N_DIR - 1; k >= 1; k--) begin
      sel_idx = DW'((int'(cur_reg) + k) % N_DIR);
      if (pend_reg[sel_idx]) sel = sel_idx;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cur_next     = cur_reg;
    phase_next   = phase_reg;
    first_next   = 1'b0;
    load         = 1'b0;
    load_val     = '0;
    elapsed_next = elapsed_reg;
    if (state_reg == S_GREEN && elapsed_reg != GMAX_M1) elapsed_next = elapsed_reg + 1'b1;
    pend_next = pend_reg | ((state_reg == S_GREEN) ? (sensor & ~cur_mask) : sensor);

    case (state_reg)
      S_ALL_RED: begin
        if (expired) begin
          if (flash_req) begin
            state_next = S_FLASH;
            phase_next = 1'b1;
            load       = 1'b1;
            load_val   = FLASH_LD;
          end else begin
            state_next     = S_GREEN;
            cur_next       = sel;
            pend_next[sel] = 1'b0;
            elapsed_next   = '0;
            first_next     = 1'b1;
          end
        end
      end
      S_GREEN: begin
        if (go_yellow) begin
          state_next = S_YELLOW;
          load       = 1'b1;
          load_val   = YELLOW_LD;
        end
      end
      S_YELLOW: begin
        if (expired) begin
          state_next = S_ALL_RED;
          load       = 1'b1;
          load_val   = ALLRED_LD;
        end
      end
      S_FLASH: begin
        if (!flash_req) begin
          state_next = S_ALL_RED;
          load       = 1'b1;
          load_val   = ALLRED_LD;
        end else if (expired) begin
          phase_next = ~phase_reg;
          load       = 1'b1;
          load_val   = FLASH_LD;
        end
      end
      default: state_next = S_ALL_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_ALL_RED;
      cur_reg     <= DW'(N_DIR - 1);
      pend_reg    <= '0;
      elapsed_reg <= '0;
      first_reg   <= 1'b0;
      phase_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cur_reg     <= cur_next;
      pend_reg    <= pend_next;
      elapsed_reg <= elapsed_next;
      first_reg   <= first_next;
      phase_reg   <= phase_next;
    end
  end

  for (genvar gi = 0; gi < N_DIR; gi++) begin : g_lamp
    assign lights[3*gi +: 3] =
      (state_reg == S_FLASH) ? (phase_reg ? ((gi == 0) ? YELLOW : RED) : DARK) :
      (state_reg == S_GREEN  && cur_reg == DW'(gi)) ? GREEN  :
      (state_reg == S_YELLOW && cur_reg == DW'(gi)) ? YELLOW : RED;
  end

  assign active_dir = cur_reg;
  assign handover   = first_reg;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench: a phase/age reference model predicts each cycle's lamps,
// and a negedge monitor compares the DUT against the queued predictions.
module tb_intersection_ctrl;

  localparam int N    = 3;
  localparam int DW   = 2;
  localparam int GMIN = 4;
  localparam int GMAX = 8;
  localparam int YT   = 2;
  localparam int ART  = 1;
  localparam int FT   = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           flash_req = 1'b0;
  logic [N-1:0]   sensor = '0;
  logic [3*N-1:0] lights;
  logic [DW-1:0]  active_dir;
  logic           handover;

  always #5 clk = ~clk;

  intersection_ctrl #(
    .N_DIR(N), .GREEN_MIN(GMIN), .GREEN_MAX(GMAX),
    .YELLOW_T(YT), .ALLRED_T(ART), .FLASH_T(FT), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sensor    (sensor),
    .flash_req (flash_req),
    .lights    (lights),
    .active_dir(active_dir),
    .handover  (handover)
  );

  typedef struct {
    logic [3*N-1:0] lights;
    logic [DW-1:0]  dir;
    logic           ho;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests  = 0;
  int   failed = 0;
  int   cyc    = 0;

  // Reference model: mode 0=all red, 1=green, 2=yellow, 3=flash; age counts
  // cycles already spent in the current phase.
  int m_mode, m_age, m_cur;
  bit m_pend[N];
  bit m_on;

  task automatic model_reset();
    m_mode = 0;
    m_age  = 0;
    m_cur  = N - 1;
    m_on   = 1'b0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [2:0] lamp;
    e.lights = '0;
    for (int i = 0; i < N; i++) begin
      lamp = 3'b100;
      if (m_mode == 1 && i == m_cur) lamp = 3'b001;
      if (m_mode == 2 && i == m_cur) lamp = 3'b010;
      if (m_mode == 3) lamp = m_on ? ((i == 0) ? 3'b010 : 3'b100) : 3'b000;
      e.lights[3*i +: 3] = lamp;
    end
    e.dir = DW'(m_cur);
    e.ho  = (m_mode == 1 && m_age == 0);
    e.cyc = 0;
    return e;
  endfunction

  task automatic model_advance(input logic [N-1:0] s, input logic f, input logic r);
    bit old_pend[N];
    bit demand;
    int g, nxt, j;
    if (r) begin
      model_reset();
      return;
    end
    demand = 1'b0;
    for (int i = 0; i < N; i++) begin
      old_pend[i] = m_pend[i];
      if (m_pend[i] || (s[i] && i != m_cur)) demand = 1'b1;
    end
    for (int i = 0; i < N; i++)
      if (s[i] && !(m_mode == 1 && i == m_cur)) m_pend[i] = 1'b1;
    case (m_mode)
      0: begin
        if (m_age + 1 >= ART) begin
          if (f) begin
            m_mode = 3; m_age = 0; m_on = 1'b1;
          end else begin
            nxt = 0;
            for (int k = 1; k <= N; k++) begin
              j = (m_cur + k) % N;
              if (old_pend[j]) begin nxt = j; break; end
            end
            m_cur = nxt; m_pend[nxt] = 1'b0; m_mode = 1; m_age = 0;
          end
        end else m_age++;
      end
      1: begin
        g = (m_age < GMAX - 1) ? m_age : GMAX - 1;
        if (g >= GMIN - 1 && (f || (demand && (!s[m_cur] || g >= GMAX - 1)))) begin
          m_mode = 2; m_age = 0;
        end else m_age++;
      end
      2: begin
        if (m_age + 1 >= YT) begin m_mode = 0; m_age = 0; end
        else m_age++;
      end
      default: begin
        if (!f) begin m_mode = 0; m_age = 0; end
        else if (m_age + 1 >= FT) begin m_on = !m_on; m_age = 0; end
        else m_age++;
      end
    endcase
  endtask

  // One clock cycle: queue the prediction for the current cycle, then drive
  // the inputs the DUT samples at the next rising edge.
  task automatic step(input logic [N-1:0] s, input logic f, input logic r);
    exp_t e;
    e = model_out();
    e.cyc = cyc;
    sb.push_back(e);
    sensor = s; flash_req = f; rst = r;
    model_advance(s, f, r);
    cyc = r ? 0 : cyc + 1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      tests++;
      if (lights !== mon_e.lights || active_dir !== mon_e.dir || handover !== mon_e.ho) begin
        failed++;
        $display("FAIL outputs cyc=%0d lights=%b exp=%b dir=%0d exp=%0d handover=%0b exp=%0b",
                 mon_e.cyc, lights, mon_e.lights, active_dir, mon_e.dir, handover, mon_e.ho);
      end
    end
  end

  initial begin
    logic [N-1:0] s;
    logic f, r;
    int sp, fp;
    rst = 1'b1;
    @(posedge clk); #1;
    model_reset();
    cyc = 0;

    $display("[TB] scenario idle after reset");
    step('0, 1'b0, 1'b1);
    repeat (52) step('0, 1'b0, 1'b0);

    $display("[TB] scenario sensor[1] pulse at cycle 2");
    step('0, 1'b0, 1'b1);
    for (int c = 0; c < 14; c++) step((c == 2) ? 3'b010 : 3'b000, 1'b0, 1'b0);

    $display("[TB] scenario sensor[0] held, sensor[2] at cycle 2");
    step('0, 1'b0, 1'b1);
    for (int c = 0; c < 18; c++) step(3'b001 | ((c == 2) ? 3'b100 : 3'b000), 1'b0, 1'b0);

    $display("[TB] scenario sensor[1] and sensor[2] together");
    step('0, 1'b0, 1'b1);
    for (int c = 0; c < 30; c++) step((c == 2) ? 3'b110 : 3'b000, 1'b0, 1'b0);

    $display("[TB] scenario flash request");
    step('0, 1'b0, 1'b1);
    for (int c = 0; c < 30; c++) step('0, (c >= 2 && c < 20), 1'b0);

    $display("[TB] scenario reset during yellow");
    step('0, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) step((c == 2) ? 3'b010 : 3'b000, 1'b0, (c == 5));
    repeat (12) step('0, 1'b0, 1'b0);

    f = 1'b0;
    for (int seg = 0; seg < 10; seg++) begin
      sp = $urandom_range(2, 70);
      fp = (seg % 3 == 2) ? 3 : 0;
      $display("[TB] random segment %0d sensor_pct=%0d flash_flip_pct=%0d", seg, sp, fp);
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < N; i++) s[i] = ($urandom_range(0, 99) < sp);
        if ($urandom_range(0, 99) < fp) f = ~f;
        if (fp == 0) f = 1'b0;
        r = ($urandom_range(0, 199) == 0);
        step(s, f, r);
      end
    end

    step('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
